// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with eight operations, a multi-cycle
// shift-add multiply, and zero/carry/overflow flags.
//
// state | meaning
// IDLE  | no result pending, ready for a new operation
// MUL   | shift-add multiply iterating (busy=1), then one cycle to register
// DONE  | result and flags valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       ctrl_aluop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // single-cycle result and flags for every opcode except MUL
  always_comb begin
    sum   = {1'b0, in1} + {1'b0, in2};
    diff  = {1'b0, in1} - {1'b0, in2};
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (ctrl_aluop)
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND:  res = in1 & in2;
      OP_OR:   res = in1 | in2;
      OP_XOR:  res = in1 ^ in2;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      OP_SRL:  res = in1 >> in2[SHW-1:0];
      default: res = '0;
    endcase
  end

  // control FSM, multiply datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out        <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
    end else if (accept) begin
      if (ctrl_aluop == OP_MUL) begin
        state     <= MUL;
        busy      <= 1'b1;
        out_valid <= 1'b0;
        acc       <= '0;
        mcand     <= {{WIDTH{1'b0}}, in1};
        mplier    <= in2;
        cnt       <= '0;
      end else begin
        state      <= DONE;
        out_valid  <= 1'b1;
        out        <= res;
        flag_zero  <= (res == '0);
        flag_carry <= res_c;
        flag_ovf   <= res_v;
      end
    end else begin
      case (state)
        MUL: begin
          if (busy) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CNT_LAST) busy <= 1'b0;
          end else begin
            // all iterations done; the extra cycle registers the product
            state      <= DONE;
            out_valid  <= 1'b1;
            out        <= acc[WIDTH-1:0];
            flag_zero  <= (acc[WIDTH-1:0] == '0);
            flag_carry <= |acc[2*WIDTH-1:WIDTH];
            flag_ovf   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table,
// hand-written backpressure and reset sequences, and random ops against
// an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [2:0]   ctrl_aluop = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         flag_zero, flag_carry, flag_ovf, busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .ctrl_aluop(ctrl_aluop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_ovf(flag_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; int a; int b; int r; int c; int v;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // reference model: plain integer arithmetic on 8-bit values
  function automatic void model(input int op, input int a, input int b,
                                output int r, output int c, output int v);
    int sa, sb, t;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r = 0; c = 0; v = 0;
    case (op)
      0: begin t = a + b; r = t % 256; c = int'(t > 255);
               v = int'((sa + sb > 127) || (sa + sb < -128)); end
      1: begin t = a - b; r = (t + 256) % 256; c = int'(a < b);
               v = int'((sa - sb > 127) || (sa - sb < -128)); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = int'(sa < sb);
      6: begin t = a * b; r = t % 256; c = int'(t > 255); end
      default: r = a >> (b % 8);
    endcase
  endfunction

  // issue one op from IDLE, wait for the result, hold it for 'stall'
  // cycles with out_ready low, then consume it
  task automatic run_op(input string name, input int op, input int a, input int b,
                        input int r, input int c, input int v, input int stall);
    int lat, busy_n;
    in1 = W'(a); in2 = W'(b); ctrl_aluop = 3'(op);
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; busy_n = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), (op == 6) ? 32'd9 : 32'd0);
    check({name, "_busy_cycles"}, 32'(busy_n), (op == 6) ? 32'd8 : 32'd0);
    check({name, "_out"}, 32'(out), 32'(r));
    check({name, "_carry"}, 32'(flag_carry), 32'(c));
    check({name, "_ovf"}, 32'(flag_ovf), 32'(v));
    check({name, "_zero"}, 32'(flag_zero), 32'(r == 0));
    repeat (stall) begin
      @(posedge clk); #1;
    end
    check({name, "_hold"}, {out_valid, in_ready, 22'd0, out},
          {1'b1, 1'b0, 22'd0, 8'(r)});
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_drain"}, {out_valid, 23'd0, out}, {1'b0, 23'd0, 8'(r)});
    out_ready = 1'b0;
  endtask

  vec_t tbl[15];

  initial begin
    int op, a, b, r, c, v;

    tbl[0]  = '{0, 'hFF, 'h01, 'h00, 1, 0};
    tbl[1]  = '{1, 'h80, 'h01, 'h7F, 0, 1};
    tbl[2]  = '{1, 'h01, 'h02, 'hFF, 1, 0};
    tbl[3]  = '{6, 'h10, 'h11, 'h10, 1, 0};
    tbl[4]  = '{6, 'h0F, 'h0F, 'hE1, 0, 0};
    tbl[5]  = '{5, 'hFF, 'h01, 'h01, 0, 0};
    tbl[6]  = '{5, 'h01, 'hFF, 'h00, 0, 0};
    tbl[7]  = '{7, 'h80, 'h0B, 'h10, 0, 0};
    tbl[8]  = '{2, 'hF0, 'h3C, 'h30, 0, 0};
    tbl[9]  = '{3, 'hF0, 'h0F, 'hFF, 0, 0};
    tbl[10] = '{4, 'hAA, 'hAA, 'h00, 0, 0};
    tbl[11] = '{0, 'h7F, 'h01, 'h80, 0, 1};
    tbl[12] = '{7, 'h81, 'h00, 'h81, 0, 0};
    tbl[13] = '{6, 'hFF, 'hFF, 'h01, 1, 0};
    tbl[14] = '{6, 'h00, 'h5A, 'h00, 0, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
    check("reset_valid_busy", {30'd0, out_valid, busy}, 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    for (int i = 0; i < 15; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].r, tbl[i].c, tbl[i].v, i % 3);
    end

    // backpressure then a no-bubble accept on release
    in1 = 8'd3; in2 = 8'd4; ctrl_aluop = 3'b000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_stall%0d", i), {out_valid, in_ready, 22'd0, out},
            {1'b1, 1'b0, 22'd0, 8'h07});
      @(posedge clk); #1;
    end
    in1 = 8'hF0; in2 = 8'h0F; ctrl_aluop = 3'b100; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_xor_result", {out_valid, 23'd0, out}, {1'b1, 23'd0, 8'hFF});
    check("bp_xor_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
    @(posedge clk); #1;
    check("bp_drain", {out_valid, 23'd0, out}, {1'b0, 23'd0, 8'hFF});
    out_ready = 1'b0;

    // reset in the middle of a multiply
    run_op("pre_rst_add", 0, 5, 5, 10, 0, 0, 0);
    in1 = 8'h12; in2 = 8'h34; ctrl_aluop = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mul_state", {29'd0, busy, out_valid, in_ready}, 32'b001);
    check("rst_mul_out", 32'(out), 32'd0);
    check("rst_mul_flags", {29'd0, flag_zero, flag_carry, flag_ovf}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_rst_add", 0, 1, 1, 2, 0, 0, 0);

    // random ops against the reference model
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      model(op, a, b, r, c, v);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, r, c, v,
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
